rename_regfile_mp: RTL

- Multi-port architectural register file with a per-register rename tag (label), successor to the single-issue register file.
- Sits between decoder/ROB issue logic and the ROB commit stage.
- Supports ISSUE_W rename slots per cycle, each reading two operands, and COMMIT_W retirements per cycle.
- Flush clears rename tags only, so architectural values persist. Adds in-bundle rename forwarding and optional commit-to-read bypass.

---
 rtl/rename_regfile_mp_if.sv | 35 +++
 rtl/rename_regfile_mp.sv | 137 +++++++++++++
 2 files changed

// File: rtl/rename_regfile_mp_if.sv
// Issue/read and commit bus of the multi-port rename register file.
// Master drives issue and commit slots; slave returns source values and tags.
interface rename_regfile_mp_if #(
  parameter int REG_WIDTH = 5,
  parameter int VAL_WIDTH = 32,
  parameter int TAG_WIDTH = 5,
  parameter int ISSUE_W   = 2,
  parameter int COMMIT_W  = 2
);
  logic [ISSUE_W-1:0]            iss_en;
  logic [ISSUE_W*REG_WIDTH-1:0]  iss_rd;
  logic [ISSUE_W*TAG_WIDTH-1:0]  iss_tag;
  logic [ISSUE_W*REG_WIDTH-1:0]  iss_rs1;
  logic [ISSUE_W*REG_WIDTH-1:0]  iss_rs2;
  logic [ISSUE_W*VAL_WIDTH-1:0]  rd_val1;
  logic [ISSUE_W*VAL_WIDTH-1:0]  rd_val2;
  logic [ISSUE_W*TAG_WIDTH-1:0]  rd_lab1;
  logic [ISSUE_W*TAG_WIDTH-1:0]  rd_lab2;
  logic [COMMIT_W-1:0]           cmt_en;
  logic [COMMIT_W*REG_WIDTH-1:0] cmt_rd;
  logic [COMMIT_W*VAL_WIDTH-1:0] cmt_val;
  logic [COMMIT_W*TAG_WIDTH-1:0] cmt_tag;

  modport master (
    output iss_en, iss_rd, iss_tag, iss_rs1, iss_rs2,
    output cmt_en, cmt_rd, cmt_val, cmt_tag,
    input  rd_val1, rd_val2, rd_lab1, rd_lab2
  );

  modport slave (
    input  iss_en, iss_rd, iss_tag, iss_rs1, iss_rs2,
    input  cmt_en, cmt_rd, cmt_val, cmt_tag,
    output rd_val1, rd_val2, rd_lab1, rd_lab2
  );
endinterface

// File: rtl/rename_regfile_mp.sv
// Multi-port architectural register file with per-register rename tags.
// Define RF_BYPASS_EN to add same-cycle commit-to-read bypass.
module rename_regfile_mp #(
  parameter int REG_SIZE  = 32,
  parameter int REG_WIDTH = 5,
  parameter int VAL_WIDTH = 32,
  parameter int TAG_WIDTH = 5,
  parameter int ISSUE_W   = 2,
  parameter int COMMIT_W  = 2
) (
  input logic                clk,
  input logic                rst_in,
  input logic                rdy_in,
  input logic                flush,
  rename_regfile_mp_if.slave bus
);

  logic [VAL_WIDTH-1:0] val_q [REG_SIZE];
  logic [VAL_WIDTH-1:0] val_d [REG_SIZE];
  logic [TAG_WIDTH-1:0] lab_q [REG_SIZE];
  logic [TAG_WIDTH-1:0] lab_d [REG_SIZE];

  logic [REG_WIDTH-1:0] c_rd;
  logic [TAG_WIDTH-1:0] c_tag;
  logic [REG_WIDTH-1:0] i_rd;

  logic [ISSUE_W-1:0][VAL_WIDTH-1:0] v1, v2;
  logic [ISSUE_W-1:0][TAG_WIDTH-1:0] l1, l2;
  logic [REG_WIDTH-1:0] src;
  logic [VAL_WIDTH-1:0] rv;
  logic [TAG_WIDTH-1:0] rl;

  // Next state: commits in slot order, then flush or issues override labels.
  always_comb begin
    c_rd  = '0;
    c_tag = '0;
    i_rd  = '0;
    for (int r = 0; r < REG_SIZE; r++) begin
      val_d[r] = val_q[r];
      lab_d[r] = lab_q[r];
    end
    for (int k = 0; k < COMMIT_W; k++) begin
      if (bus.cmt_en[k]) begin
        c_rd  = bus.cmt_rd[k*REG_WIDTH +: REG_WIDTH];
        c_tag = bus.cmt_tag[k*TAG_WIDTH +: TAG_WIDTH];
        if (c_rd != '0) begin
          val_d[c_rd] = bus.cmt_val[k*VAL_WIDTH +: VAL_WIDTH];
          // Only the current producer may clear; a younger rename keeps its tag.
          lab_d[c_rd] = (lab_q[c_rd] == c_tag) ? '0 : lab_q[c_rd];
        end
      end
    end
    if (flush) begin
      for (int r = 0; r < REG_SIZE; r++) begin
        lab_d[r] = '0;
      end
    end else begin
      for (int j = 0; j < ISSUE_W; j++) begin
        if (bus.iss_en[j]) begin
          i_rd = bus.iss_rd[j*REG_WIDTH +: REG_WIDTH];
          if (i_rd != '0) begin
            lab_d[i_rd] = bus.iss_tag[j*TAG_WIDTH +: TAG_WIDTH];
          end
        end
      end
    end
  end

  // State register: async clear, updates gated by global ready.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int r = 0; r < REG_SIZE; r++) begin
        val_q[r] <= '0;
        lab_q[r] <= '0;
      end
    end else if (rdy_in) begin
      for (int r = 0; r < REG_SIZE; r++) begin
        val_q[r] <= val_d[r];
        lab_q[r] <= lab_d[r];
      end
    end
  end

  // Read ports: registered state, optional commit bypass, then in-bundle forward.
  always_comb begin
    v1  = '0;
    v2  = '0;
    l1  = '0;
    l2  = '0;
    src = '0;
    rv  = '0;
    rl  = '0;
    for (int j = 0; j < ISSUE_W; j++) begin
      for (int p = 0; p < 2; p++) begin
        src = (p == 0) ? bus.iss_rs1[j*REG_WIDTH +: REG_WIDTH]
                       : bus.iss_rs2[j*REG_WIDTH +: REG_WIDTH];
        rv = '0;
        rl = '0;
        if (src != '0) begin
          rv = val_q[src];
          rl = lab_q[src];
`ifdef RF_BYPASS_EN
          for (int k = 0; k < COMMIT_W; k++) begin
            if (bus.cmt_en[k] &&
                bus.cmt_rd[k*REG_WIDTH +: REG_WIDTH] == src &&
                bus.cmt_tag[k*TAG_WIDTH +: TAG_WIDTH] == lab_q[src]) begin
              rv = bus.cmt_val[k*VAL_WIDTH +: VAL_WIDTH];
              rl = '0;
            end
          end
`endif
          // An older slot renaming the same register this cycle owns the tag.
          for (int i = 0; i < j; i++) begin
            if (bus.iss_en[i] &&
                bus.iss_rd[i*REG_WIDTH +: REG_WIDTH] == src) begin
              rv = '0;
              rl = bus.iss_tag[i*TAG_WIDTH +: TAG_WIDTH];
            end
          end
        end
        if (p == 0) begin
          v1[j] = rv;
          l1[j] = rl;
        end else begin
          v2[j] = rv;
          l2[j] = rl;
        end
      end
    end
  end

  assign bus.rd_val1 = v1;
  assign bus.rd_val2 = v2;
  assign bus.rd_lab1 = l1;
  assign bus.rd_lab2 = l2;

endmodule
